// File: rtl/if_fetch_unit_if.sv
// Bundle of the fetch-stage control, instruction-memory and IF/ID output signals.
// Optional perf counters appear only when IF_FETCH_PERF_CNT_EN is defined.
interface if_fetch_unit_if #(
    parameter int WORD_LEN = 32
) ();
    logic                FREEZE;
    logic                BRANCH_TAKEN;
    logic [WORD_LEN-1:0] BRANCH_ADDR;
    // Memory handshake: IMEM_REQ/IMEM_ADDR are held stable from the cycle REQ
    // rises until the cycle IMEM_ACK=1 (ACK may coincide with REQ); the word
    // transfers on the posedge where both are high.
    logic                IMEM_REQ;
    logic [WORD_LEN-1:0] IMEM_ADDR;
    logic                IMEM_ACK;
    logic [WORD_LEN-1:0] IMEM_RDATA;
    logic                VALID_OUT;
    logic [WORD_LEN-1:0] PC_OUT;
    logic [WORD_LEN-1:0] INSTRUCTION_OUT;
    logic                dbg_state;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [WORD_LEN-1:0] STALL_CYCLES;
    logic [WORD_LEN-1:0] REDIRECTS;

    modport master (
        input  FREEZE, BRANCH_TAKEN, BRANCH_ADDR, IMEM_ACK, IMEM_RDATA,
        output IMEM_REQ, IMEM_ADDR, VALID_OUT, PC_OUT, INSTRUCTION_OUT, dbg_state,
        output STALL_CYCLES, REDIRECTS
    );
    modport slave (
        output FREEZE, BRANCH_TAKEN, BRANCH_ADDR, IMEM_ACK, IMEM_RDATA,
        input  IMEM_REQ, IMEM_ADDR, VALID_OUT, PC_OUT, INSTRUCTION_OUT, dbg_state,
        input  STALL_CYCLES, REDIRECTS
    );
`else
    modport master (
        input  FREEZE, BRANCH_TAKEN, BRANCH_ADDR, IMEM_ACK, IMEM_RDATA,
        output IMEM_REQ, IMEM_ADDR, VALID_OUT, PC_OUT, INSTRUCTION_OUT, dbg_state
    );
    modport slave (
        output FREEZE, BRANCH_TAKEN, BRANCH_ADDR, IMEM_ACK, IMEM_RDATA,
        input  IMEM_REQ, IMEM_ADDR, VALID_OUT, PC_OUT, INSTRUCTION_OUT, dbg_state
    );
`endif
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, req/ack memory fetch, single-entry output buffer.
// Optional stall/redirect counters are enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter int                  WORD_LEN     = 32,
    parameter logic [WORD_LEN-1:0] RESET_VECTOR = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    if_fetch_unit_if.master  bus
);
    typedef enum logic {S_FETCH, S_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [WORD_LEN-1:0] pc_q, pc_d;
    logic [WORD_LEN-1:0] drain_addr_q, drain_addr_d;
    logic                valid_q, valid_d;
    logic [WORD_LEN-1:0] pc_out_q, pc_out_d;
    logic [WORD_LEN-1:0] instr_q, instr_d;
    logic                imem_req;
    logic [WORD_LEN-1:0] imem_addr;
    logic [WORD_LEN-1:0] pc_plus4;
    logic                consume;
    logic                fill;

    assign pc_plus4 = pc_q + WORD_LEN'(4);
    assign consume  = valid_q & ~bus.FREEZE;

    // A new request is only raised when the buffer will be free on the ACK edge.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_q;
        if (!RESET) begin
            case (state_q)
                S_FETCH: imem_req = ~valid_q | ~bus.FREEZE;
                S_DRAIN: begin
                    imem_req  = 1'b1;
                    imem_addr = drain_addr_q;
                end
                default: imem_req = 1'b0;
            endcase
        end
    end

    assign fill = (state_q == S_FETCH) & imem_req & bus.IMEM_ACK;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        valid_d      = valid_q;
        pc_out_d     = pc_out_q;
        instr_d      = instr_q;
        if (bus.BRANCH_TAKEN) begin
            valid_d  = 1'b0;
            pc_out_d = '0;
            instr_d  = '0;
            pc_d     = bus.BRANCH_ADDR;
            // An unacknowledged request must still complete; its data is thrown away.
            if (imem_req && !bus.IMEM_ACK) begin
                state_d      = S_DRAIN;
                drain_addr_d = imem_addr;
            end else if (imem_req && bus.IMEM_ACK) begin
                state_d = S_FETCH;
            end
        end else begin
            if (fill) begin
                valid_d  = 1'b1;
                pc_out_d = pc_plus4;
                instr_d  = bus.IMEM_RDATA;
                pc_d     = pc_plus4;
            end else if (consume) begin
                valid_d  = 1'b0;
                pc_out_d = '0;
                instr_d  = '0;
            end
            if (state_q == S_DRAIN && bus.IMEM_ACK) begin
                state_d = S_FETCH;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_VECTOR;
            drain_addr_q <= '0;
            valid_q      <= 1'b0;
            pc_out_q     <= '0;
            instr_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            valid_q      <= valid_d;
            pc_out_q     <= pc_out_d;
            instr_q      <= instr_d;
        end
    end

    assign bus.IMEM_REQ        = imem_req;
    assign bus.IMEM_ADDR       = imem_addr;
    assign bus.VALID_OUT       = valid_q;
    assign bus.PC_OUT          = pc_out_q;
    assign bus.INSTRUCTION_OUT = instr_q;
    assign bus.dbg_state       = (state_q == S_DRAIN);

`ifdef IF_FETCH_PERF_CNT_EN
    logic [WORD_LEN-1:0] stall_q, stall_d;
    logic [WORD_LEN-1:0] redir_q, redir_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        redir_d = redir_q;
        if (imem_req && !bus.IMEM_ACK && !(&stall_q)) stall_d = stall_q + WORD_LEN'(1);
        if (bus.BRANCH_TAKEN && !(&redir_q))          redir_d = redir_q + WORD_LEN'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_q <= '0;
            redir_q <= '0;
        end else begin
            stall_q <= stall_d;
            redir_q <= redir_d;
        end
    end

    assign bus.STALL_CYCLES = stall_q;
    assign bus.REDIRECTS    = redir_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: random-latency memory, directed then random stimulus.
module tb_if_fetch_unit;
  localparam int W = 32;
  localparam logic [W-1:0] RV    = 32'hFFFF_FFF8;
  localparam logic [W-1:0] XOR_K = 32'hA5A5_A5A5;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  if_fetch_unit_if #(.WORD_LEN(W)) fetch_if ();

  if_fetch_unit #(.WORD_LEN(W), .RESET_VECTOR(RV)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (fetch_if.master)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int consumed = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0] next_pc = RV;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int mem_lat   = 1;
  int mem_wait  = 0;
  bit mem_busy  = 0;
  bit lat_rand  = 0;
  int lat_fixed = 1;

  initial begin
    fetch_if.IMEM_ACK   = 1'b0;
    fetch_if.IMEM_RDATA = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (RESET) begin
        fetch_if.IMEM_ACK = 1'b0;
        mem_wait = 0;
        mem_busy = 0;
      end else if (fetch_if.IMEM_REQ) begin
        if (mem_wait >= mem_lat - 1) begin
          fetch_if.IMEM_ACK   = 1'b1;
          fetch_if.IMEM_RDATA = fetch_if.IMEM_ADDR ^ XOR_K;
          mem_wait = 0;
          mem_busy = 0;
          mem_lat  = lat_rand ? int'($urandom_range(1, 4)) : lat_fixed;
        end else begin
          fetch_if.IMEM_ACK   = 1'b0;
          fetch_if.IMEM_RDATA = $urandom;
          mem_wait++;
          mem_busy = 1;
        end
      end else begin
        fetch_if.IMEM_ACK   = 1'b0;
        fetch_if.IMEM_RDATA = $urandom;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic fz, input logic br, input logic [W-1:0] ba);
    @(negedge CLK);
    RESET                 = rst;
    fetch_if.FREEZE       = fz;
    fetch_if.BRANCH_TAKEN = br;
    fetch_if.BRANCH_ADDR  = br ? ba : W'($urandom);
    if (rst) begin
      exp_q.delete();
      next_pc = RV;
    end else if (br) begin
      exp_q.delete();
      next_pc = ba;
    end
    // Program order from the last redirect: addr, addr+4, ... with PC_OUT = addr+4.
    while (exp_q.size() < 4) begin
      exp_q.push_back({next_pc + 32'd4, next_pc ^ XOR_K});
      next_pc = next_pc + 32'd4;
    end
  endtask

  task automatic wait_mem(input int w);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_busy && mem_wait == w) begin
        found = 1;
        break;
      end
      drive(1'b0, 1'b0, 1'b0, '0);
      #3;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL wait_mem: no request reached wait %0d within 30 cycles", w);
    end
  endtask

  // ---------------- monitor / reference model ----------------
  bit started = 0;
  bit drain = 0;
  bit prev_rst = 0, prev_pend = 0, prev_hold = 0;
  logic [W-1:0] fetch_pc = RV, stale_addr = '0;
  logic [W-1:0] prev_addr, prev_pco, prev_ins;
  logic [W-1:0] stall_m = '0, redir_m = '0;

  initial begin
    logic rst, fz, br, req, ack, v, exp_req;
    logic [W-1:0] ba, addr, pco, ins;
    logic [2*W-1:0] e;
    forever begin
      @(negedge CLK);
      #2;
      rst = RESET; fz = fetch_if.FREEZE; br = fetch_if.BRANCH_TAKEN; ba = fetch_if.BRANCH_ADDR;
      req = fetch_if.IMEM_REQ; ack = fetch_if.IMEM_ACK; addr = fetch_if.IMEM_ADDR;
      v = fetch_if.VALID_OUT; pco = fetch_if.PC_OUT; ins = fetch_if.INSTRUCTION_OUT;
`ifdef IF_FETCH_PERF_CNT_EN
      if (started) begin
        check("stall_cycles", fetch_if.STALL_CYCLES, stall_m);
        check("redirects", fetch_if.REDIRECTS, redir_m);
      end
`endif
      if (prev_rst) begin
        check("reset_valid", W'(v), '0);
        check("reset_pc_out", pco, '0);
        check("reset_instr", ins, '0);
      end
      if (rst) begin
        check("reset_req", W'(req), '0);
        drain = 0; fetch_pc = RV; prev_pend = 0; prev_hold = 0;
        stall_m = '0; redir_m = '0; started = 1;
      end else if (started) begin
        if (!v) check("nop_when_invalid", ins, '0);
        exp_req = drain ? 1'b1 : (!v || !fz);
        check("imem_req", W'(req), W'(exp_req));
        if (req) check("imem_addr", addr, drain ? stale_addr : fetch_pc);
        if (prev_pend) begin
          check("req_held", W'(req), W'(1));
          check("addr_held", addr, prev_addr);
        end
        if (prev_hold) begin
          check("hold_valid", W'(v), W'(1));
          check("hold_pc_out", pco, prev_pco);
          check("hold_instr", ins, prev_ins);
        end
        if (v && !fz && !br) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL consume: instruction pc_out %h with empty expected queue", pco);
          end else begin
            e = exp_q.pop_front();
            check("pc_out", pco, e[2*W-1:W]);
            check("instruction_out", ins, e[W-1:0]);
          end
          consumed++;
        end
        if (req && !ack && stall_m != '1) stall_m = stall_m + 1;
        if (br && redir_m != '1) redir_m = redir_m + 1;
        if (br) begin
          fetch_pc = ba;
          if (req && !ack) begin
            if (!drain) stale_addr = addr;
            drain = 1;
          end else if (req && ack) begin
            drain = 0;
          end
        end else if (req && ack) begin
          if (drain) drain = 0;
          else fetch_pc = fetch_pc + 32'd4;
        end
        prev_pend = req && !ack;
        prev_addr = addr;
        prev_hold = v && fz && !br;
        prev_pco  = pco;
        prev_ins  = ins;
      end
      prev_rst = rst;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    fetch_if.FREEZE       = 1'b0;
    fetch_if.BRANCH_TAKEN = 1'b0;
    fetch_if.BRANCH_ADDR  = '0;
    repeat (2) drive(1'b1, 1'b0, 1'b0, '0);
    // zero-latency streaming across the 0xFFFFFFFC -> 0 wrap
    repeat (12) drive(1'b0, 1'b0, 1'b0, '0);
    // fixed 3-cycle latency
    lat_fixed = 3;
    repeat (15) drive(1'b0, 1'b0, 1'b0, '0);
    // freeze with full buffer
    lat_fixed = 1;
    repeat (6) drive(1'b0, 1'b0, 1'b0, '0);
    repeat (5) drive(1'b0, 1'b1, 1'b0, '0);
    repeat (8) drive(1'b0, 1'b0, 1'b0, '0);
    // branch mid-way through a 3-cycle request
    lat_fixed = 3;
    wait_mem(1);
    drive(1'b0, 1'b0, 1'b1, 32'h100);
    repeat (12) drive(1'b0, 1'b0, 1'b0, '0);
    // branch on the ACK cycle with FREEZE high
    wait_mem(2);
    drive(1'b0, 1'b1, 1'b1, 32'h200);
    repeat (10) drive(1'b0, 1'b0, 1'b0, '0);
    // reset mid-request
    wait_mem(1);
    drive(1'b1, 1'b0, 1'b0, '0);
    repeat (10) drive(1'b0, 1'b0, 1'b0, '0);
    // random traffic
    lat_rand = 1;
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) == 0,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 6,
            W'($urandom) & ~W'(3));
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    #3;
    n_checks++;
    if (consumed < 150) begin
      n_fail++;
      $display("FAIL progress: consumed %0d instructions, required at least 150", consumed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter, issues requests to the instruction memory over a req/ack handshake, and produces the PC_IN/INSTRUCTION_IN pair consumed by the IF/ID pipeline register.
- Honours FREEZE from hazard detection and redirects on BRANCH_TAKEN from the branch-resolution stage.
- Holds one fetched instruction in a single-entry output buffer, so memory latency and pipeline stalls are decoupled.

Parameters:
- WORD_LEN, 32, width of PC, addresses and instructions.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- FREEZE  in  1  pipeline stall. While high, the output buffer is not consumed.
- BRANCH_TAKEN  in  1  one-cycle redirect strobe.
- BRANCH_ADDR  in  WORD_LEN  redirect target, valid when BRANCH_TAKEN=1.
- IMEM_REQ  out  1  fetch request.
- IMEM_ADDR  out  WORD_LEN  fetch address; equals the PC register.
- IMEM_ACK  in  1  memory response; may assert in the same cycle as IMEM_REQ.
- IMEM_RDATA  in  WORD_LEN  instruction word, valid when IMEM_ACK=1.
- VALID_OUT  out  1  output buffer holds a live instruction.
- PC_OUT  out  WORD_LEN  fetched address + 4. Drives the pipe register PC input.
- INSTRUCTION_OUT  out  WORD_LEN  buffered instruction; forced to 0 (NOP) when VALID_OUT=0.

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Reset values:
  - PC = RESET_VECTOR.
  - State = S_FETCH.
  - Buffer empty: VALID_OUT=0, PC_OUT=0, INSTRUCTION_OUT=0.
  - IMEM_REQ=0 in the reset cycle; it may assert in the first cycle after RESET deasserts.
- RESET mid-request: the request is abandoned. The memory shares RESET and drops it too.
- Consume: the buffer is consumed at a posedge when VALID_OUT=1 and FREEZE=0.
- States:
  - S_FETCH: IMEM_REQ = (~VALID_OUT | ~FREEZE). IMEM_ADDR = PC.
  - S_DRAIN: IMEM_REQ=1. IMEM_ADDR = the stale address held in DRAIN_ADDR. The returning data is discarded.
- Handshake rule: once IMEM_REQ is raised, it and IMEM_ADDR stay stable until IMEM_ACK. The IMEM_REQ equation above guarantees the buffer is empty, or is being consumed, on the ACK cycle.
- Accepted ACK in S_FETCH (no branch that cycle):
  - buffer <= {IMEM_RDATA, PC+4}, VALID_OUT <= 1.
  - PC <= PC+4.
  - A fill and a consume on the same edge are legal, giving 1 instruction/cycle with zero-latency memory.
- Consume without ACK: VALID_OUT <= 0.
- Priority: RESET > BRANCH_TAKEN > ACK/consume. BRANCH_TAKEN acts regardless of FREEZE. On BRANCH_TAKEN:
  - Buffer cleared (VALID_OUT <= 0) and PC <= BRANCH_ADDR.
  - If IMEM_REQ=1 and IMEM_ACK=0: DRAIN_ADDR <= the old address, then go to S_DRAIN.
  - If IMEM_ACK=1 the same cycle: data dropped, stay in S_FETCH.
  - If IMEM_REQ=0: stay in S_FETCH.
- In S_DRAIN:
  - On IMEM_ACK: data dropped, go to S_FETCH.
  - A further BRANCH_TAKEN updates PC (latest target wins) and stays in S_DRAIN unless ACK arrives the same cycle.
- Arithmetic: PC+4 wraps modulo 2^WORD_LEN, so 0xFFFFFFFC -> 0x00000000. No alignment check.
- Buffer stability: while VALID_OUT=1 and FREEZE=1 with no branch, PC_OUT and INSTRUCTION_OUT are held unchanged.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- When defined, two output ports are added:
  - STALL_CYCLES (WORD_LEN): counts cycles with IMEM_REQ=1 and IMEM_ACK=0.
  - REDIRECTS (WORD_LEN): counts BRANCH_TAKEN cycles.
- Both counters reset to 0 on RESET and saturate at all-ones.
- When not defined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then release with IMEM_ACK tied to IMEM_REQ, RDATA=addr^0xA5A5A5A5 -> IMEM_ADDR 0,4,8 on consecutive cycles; VALID_OUT high from the 2nd cycle; PC_OUT 4,8,12; INSTRUCTION_OUT 0xA5A5A5A5, 0xA5A5A5A1, 0xA5A5A5AD.
- Memory with fixed 3-cycle ACK latency -> IMEM_REQ/IMEM_ADDR held stable 3 cycles per fetch; one instruction every 3 cycles; VALID_OUT drops between fetches when FREEZE=0.
- FREEZE=1 for 5 cycles with the buffer full -> PC_OUT/INSTRUCTION_OUT unchanged, IMEM_REQ=0; after release, streaming resumes with no instruction lost or duplicated.
- BRANCH_TAKEN=1, BRANCH_ADDR=0x100, mid-way through a 3-cycle request to 0x8 -> VALID_OUT=0 next cycle; stale ACK for 0x8 discarded; next IMEM_ADDR=0x100 and first PC_OUT=0x104.
- Branch to 0x200 in the same cycle as ACK, with FREEZE=1 -> ACK data dropped, buffer cleared, next IMEM_ADDR=0x200.
- RESET_VECTOR=0xFFFFFFF8 -> IMEM_ADDR 0xFFFFFFF8, 0xFFFFFFFC, 0x0; PC_OUT for the 0xFFFFFFFC fetch is 0x0. RESET asserted mid-request -> IMEM_REQ=0 next cycle and the PC returns to RESET_VECTOR.
